// File: rtl/nn_layer_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and the
// default WAIT timeout.
package nn_layer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    localparam int DEF_WAIT_TIMEOUT = 1024;

endpackage

// File: rtl/layer_out_capture.sv
// Per-neuron result capture: value registers, captured flags, all-captured
// detect and the drain read mux.
// Ports: i_clear clears flags, i_en enables capture, i_neuron_out/
// i_neuron_outvalid are the neuron results, i_rd_idx selects o_rd_data,
// o_all_captured is high once every flag is set.
module layer_out_capture #(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16,
    parameter int IW        = (numNeuron > 1) ? $clog2(numNeuron) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_clear,
    input  logic                           i_en,
    input  logic [numNeuron*dataWidth-1:0] i_neuron_out,
    input  logic [numNeuron-1:0]           i_neuron_outvalid,
    input  logic [IW-1:0]                  i_rd_idx,
    output logic                           o_all_captured,
    output logic [dataWidth-1:0]           o_rd_data
);

    logic [dataWidth-1:0] r_val [numNeuron];
    logic [numNeuron-1:0] r_flag;

    // A repeat pulse simply overwrites the stored value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= '0;
            for (int k = 0; k < numNeuron; k++) begin
                r_val[k] <= '0;
            end
        end else if (i_clear) begin
            r_flag <= '0;
        end else if (i_en) begin
            for (int k = 0; k < numNeuron; k++) begin
                if (i_neuron_outvalid[k]) begin
                    r_flag[k] <= 1'b1;
                    r_val[k]  <= i_neuron_out[k*dataWidth +: dataWidth];
                end
            end
        end
    end

    assign o_all_captured = &r_flag;

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < numNeuron; k++) begin
            if (i_rd_idx == IW'(k)) begin
                o_rd_data = r_val[k];
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one neural layer pass: streams inputs to all neurons, waits for
// every neuron result, then drains the results serially with valid/ready.
// Ports: start/busy/done/error control, in_addr/in_data input buffer,
// neuron_in/neuron_in_valid broadcast, neuron_out/neuron_outvalid results,
// out_data/out_valid/out_ready result stream.
// Optional LAYER_SEQ_PERF_EN adds a 32-bit busy cycle_count output.
module layer_sequencer
    import nn_layer_pkg::*;
#(
    parameter int numWeight   = 784,
    parameter int numNeuron   = 30,
    parameter int dataWidth   = 16,
    parameter int waitTimeout = DEF_WAIT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic [$clog2(numWeight)-1:0]   in_addr,
    input  logic [dataWidth-1:0]           in_data,
    output logic [dataWidth-1:0]           neuron_in,
    output logic                           neuron_in_valid,
    input  logic [numNeuron*dataWidth-1:0] neuron_out,
    input  logic [numNeuron-1:0]           neuron_outvalid,
    output logic [dataWidth-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           done,
    output logic                           error
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0]                    cycle_count
`endif
);

    localparam int AW = $clog2(numWeight);
    localparam int IW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
    localparam int TW = $clog2(waitTimeout + 1);

    seq_state_t           r_state;
    logic [AW-1:0]        r_addr;
    logic                 r_tail;
    logic                 r_nvalid;
    logic                 r_done;
    logic                 r_error;
    logic [IW-1:0]        r_idx;
    logic [TW-1:0]        r_wcnt;

    logic                 w_start;
    logic                 w_cap_en;
    logic                 w_all;
    logic                 w_out_valid;
    logic                 w_xfer;
    logic [dataWidth-1:0] w_rd_data;

    assign w_start     = (r_state == IDLE) && start;
    assign w_cap_en    = (r_state == STREAM) || (r_state == WAIT);
    assign w_out_valid = (r_state == DRAIN);
    assign w_xfer      = w_out_valid && out_ready;

    // r_tail marks the extra STREAM cycle in which the last sample
    // (read one cycle after its address) is still on neuron_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_tail   <= 1'b0;
            r_nvalid <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_idx    <= '0;
            r_wcnt   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_nvalid <= (r_state == STREAM) && !r_tail;
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_error <= 1'b0;
                        r_addr  <= '0;
                        r_tail  <= 1'b0;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (r_tail) begin
                        r_tail  <= 1'b0;
                        r_addr  <= '0;
                        r_wcnt  <= '0;
                        r_state <= WAIT;
                    end else if (r_addr == AW'(numWeight - 1)) begin
                        r_tail <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                WAIT: begin
                    if (w_all) begin
                        r_idx   <= '0;
                        r_state <= DRAIN;
                    end else if (r_wcnt == TW'(waitTimeout - 1)) begin
                        r_error <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_xfer) begin
                        if (r_idx == IW'(numNeuron - 1)) begin
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    layer_out_capture #(
        .numNeuron (numNeuron),
        .dataWidth (dataWidth),
        .IW        (IW)
    ) u_capture (
        .clk               (clk),
        .rst               (rst),
        .i_clear           (w_start),
        .i_en              (w_cap_en),
        .i_neuron_out      (neuron_out),
        .i_neuron_outvalid (neuron_outvalid),
        .i_rd_idx          (r_idx),
        .o_all_captured    (w_all),
        .o_rd_data         (w_rd_data)
    );

    assign busy            = (r_state != IDLE);
    assign in_addr         = r_addr;
    assign neuron_in       = r_nvalid ? in_data : '0;
    assign neuron_in_valid = r_nvalid;
    assign out_valid       = w_out_valid;
    assign out_data        = w_out_valid ? w_rd_data : '0;
    assign done            = r_done;
    assign error           = r_error;

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (w_start) begin
            r_cycles <= '0;
        end else if (busy) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    assign cycle_count = r_cycles;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer (numWeight=4, numNeuron=3,
// dataWidth=16, waitTimeout=8) against a behavioural pass model.
module tb_layer_sequencer;

    localparam int NW = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int WT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic [1:0]        in_addr;
    logic [DW-1:0]     in_data = '0;
    logic [DW-1:0]     neuron_in;
    logic              neuron_in_valid;
    logic [NN*DW-1:0]  neuron_out = '0;
    logic [NN-1:0]     neuron_outvalid = '0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              done;
    logic              error;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0]       cycle_count;
`endif

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    int early_done;
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] exp_v [NN];
    logic [DW-1:0] got_q [$];

    layer_sequencer #(
        .numWeight   (NW),
        .numNeuron   (NN),
        .dataWidth   (DW),
        .waitTimeout (WT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .neuron_in       (neuron_in),
        .neuron_in_valid (neuron_in_valid),
        .neuron_out      (neuron_out),
        .neuron_outvalid (neuron_outvalid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .done            (done),
        .error           (error)
`ifdef LAYER_SEQ_PERF_EN
        ,
        .cycle_count     (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    // Input buffer: one-cycle read latency.
    always @(posedge clk) in_data <= mem[in_addr];

    always @(negedge clk) if (busy) busy_cnt++;

    task automatic rand_mem();
        for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
    endtask

    // Starts a pass, checks the input stream, and drives neuron results.
    // mode 0: random pulses (repeats, simultaneous), all neurons covered
    // mode 1: neurons 2,0,1 with 0x30,0x10,0x20
    // mode 2: only neurons 0 and 1 respond
    task automatic start_and_feed(input bit chained, input int mode);
        logic [NN-1:0] have;
        logic [NN-1:0] pv;
        logic [DW-1:0] v;
        logic          vexp;
        have = '0;
        if (!chained) @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= NW + 3; c++) begin
            @(negedge clk);
            start = (mode == 0 && c == 3);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL stream_busy c=%0d got=%b want=1", c, busy);
            end
            if (c <= NW) begin
                total++;
                if (in_addr !== 2'(c - 1)) begin
                    bad++;
                    $display("FAIL in_addr c=%0d got=%0d want=%0d",
                             c, in_addr, c - 1);
                end
            end
            vexp = (c >= 2 && c <= NW + 1);
            total++;
            if (neuron_in_valid !== vexp) begin
                bad++;
                $display("FAIL nin_valid c=%0d got=%b want=%b",
                         c, neuron_in_valid, vexp);
            end
            if (vexp) begin
                total++;
                if (neuron_in !== mem[c-2]) begin
                    bad++;
                    $display("FAIL neuron_in c=%0d got=%h want=%h",
                             c, neuron_in, mem[c-2]);
                end
            end
            pv = '0;
            if (c <= NW + 2) begin
                case (mode)
                    0: begin
                        pv = NN'($urandom);
                        if (c == NW + 2) pv = pv | ~have;
                    end
                    1: if (c <= 3) pv[(c == 1) ? 2 : (c == 2) ? 0 : 1] = 1'b1;
                    2: if (c <= 2) pv[c-1] = 1'b1;
                    default: pv = '0;
                endcase
            end
            for (int k = 0; k < NN; k++) begin
                if (pv[k]) begin
                    v = (mode == 1) ? DW'(16 * (k + 1)) : DW'($urandom);
                    neuron_out[k*DW +: DW] = v;
                    exp_v[k] = v;
                    have[k] = 1'b1;
                end
            end
            neuron_outvalid = pv;
        end
    endtask

    // Collects drained beats; returns at the negedge where done should show.
    task automatic drain(input bit rnd);
        got_q.delete();
        early_done = 0;
        for (int c = 0; c < 100 && got_q.size() < NN; c++) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom) : 1'b1;
            if (done) early_done++;
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, neuron_in_valid, out_valid, done, error} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=00000",
                     {busy, neuron_in_valid, out_valid, done, error});
        end
        total++;
        if (in_addr !== 2'd0) begin
            bad++;
            $display("FAIL reset_addr got=%0d want=0", in_addr);
        end
        total++;
        if (neuron_in !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h want=0/0", neuron_in, out_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < NW; i++) mem[i] = DW'(i + 1);
        start_and_feed(1'b0, 1);
        drain(1'b0);
        total++;
        if (got_q.size() != NN) begin
            bad++;
            $display("FAIL basic_beats got=%0d want=%0d", got_q.size(), NN);
        end
        for (int i = 0; i < NN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== DW'(16 * (i + 1))) begin
                bad++;
                $display("FAIL basic_data i=%0d got=%h want=%h",
                         i, got_q[i], 16 * (i + 1));
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || early_done != 0) begin
            bad++;
            $display("FAIL basic_done got=%b%b/%0d want=10/0",
                     done, busy, early_done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse got=%b want=0", done);
        end
    endtask

    task automatic test_backpressure();
        rand_mem();
        start_and_feed(1'b0, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_v[0]) begin
                bad++;
                $display("FAIL bp_hold c=%0d got=%b/%h want=1/%h",
                         c, out_valid, out_data, exp_v[0]);
            end
        end
        drain(1'b0);
        total++;
        if (got_q.size() != NN) begin
            bad++;
            $display("FAIL bp_beats got=%0d want=%0d", got_q.size(), NN);
        end
        for (int i = 0; i < NN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_v[i]) begin
                bad++;
                $display("FAIL bp_data i=%0d got=%h want=%h",
                         i, got_q[i], exp_v[i]);
            end
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL bp_done got=%b want=1", done);
        end
    endtask

    task automatic test_timeout();
        int b0;
        int dn;
        rand_mem();
        b0 = busy_cnt;
        dn = 0;
        start_and_feed(1'b0, 2);
        for (int c = 0; c < 40 && busy; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        total++;
        if (busy !== 1'b0 || error !== 1'b1 || dn != 0) begin
            bad++;
            $display("FAIL timeout got=busy%b err%b done%0d want=busy0 err1 done0",
                     busy, error, dn);
        end
        total++;
        if (busy_cnt - b0 != NW + 1 + WT) begin
            bad++;
            $display("FAIL timeout_len got=%0d want=%0d",
                     busy_cnt - b0, NW + 1 + WT);
        end
        repeat (3) @(negedge clk);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b want=1", error);
        end
        start_and_feed(1'b0, 0);
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%b want=0", error);
        end
        drain(1'b1);
        total++;
        if (got_q.size() != NN || done !== 1'b1) begin
            bad++;
            $display("FAIL recover got=%0d/%b want=%0d/1",
                     got_q.size(), done, NN);
        end
    endtask

    task automatic test_reset_mid();
        rand_mem();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10 && in_addr != 2'd2; c++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, neuron_in_valid, out_valid, done, error} !== 5'b0
            || in_addr !== 2'd0 || neuron_in !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL mid_reset got=%b a%0d n%h o%h want=00000 a0 n0 o0",
                     {busy, neuron_in_valid, out_valid, done, error},
                     in_addr, neuron_in, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        rand_mem();
        start_and_feed(1'b0, 0);
        drain(1'b1);
        total++;
        if (got_q.size() != NN) begin
            bad++;
            $display("FAIL post_rst_beats got=%0d want=%0d", got_q.size(), NN);
        end
        for (int i = 0; i < NN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_v[i]) begin
                bad++;
                $display("FAIL post_rst_data i=%0d got=%h want=%h",
                         i, got_q[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            rand_mem();
            start_and_feed(1'b0, 0);
            drain(1'b1);
            total++;
            if (got_q.size() != NN) begin
                bad++;
                $display("FAIL rnd_beats it=%0d got=%0d want=%0d",
                         it, got_q.size(), NN);
            end
            for (int i = 0; i < NN && i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_v[i]) begin
                    bad++;
                    $display("FAIL rnd_data it=%0d i=%0d got=%h want=%h",
                             it, i, got_q[i], exp_v[i]);
                end
            end
            total++;
            if (done !== 1'b1 || busy !== 1'b0 || early_done != 0) begin
                bad++;
                $display("FAIL rnd_done it=%0d got=%b%b/%0d want=10/0",
                         it, done, busy, early_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        rand_mem();
        start_and_feed(1'b0, 0);
        drain(1'b0);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got=%b want=1", done);
        end
        rand_mem();
        start_and_feed(1'b1, 0);
        drain(1'b1);
        total++;
        if (got_q.size() != NN || done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second got=%0d/%b want=%0d/1",
                     got_q.size(), done, NN);
        end
        for (int i = 0; i < NN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_v[i]) begin
                bad++;
                $display("FAIL b2b_data i=%0d got=%h want=%h",
                         i, got_q[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_perf();
`ifdef LAYER_SEQ_PERF_EN
        int b0;
        int want;
        rand_mem();
        b0 = busy_cnt;
        start_and_feed(1'b0, 1);
        drain(1'b0);
        want = busy_cnt - b0;
        total++;
        if (cycle_count !== 32'(want)) begin
            bad++;
            $display("FAIL cycle_count got=%0d want=%0d", cycle_count, want);
        end
        repeat (3) @(negedge clk);
        total++;
        if (cycle_count !== 32'(want)) begin
            bad++;
            $display("FAIL cycle_frozen got=%0d want=%0d", cycle_count, want);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
